aes_ctr_sched: RTL and testbench

Sequencer that runs the pipelined AES-256 encrypt core (one block per cycle, global `en` stall) in CTR mode. It generates counter blocks, feeds them to the core with a fixed key, and tracks in-flight blocks with a valid shift register. Plaintext is held in a FIFO aligned to core latency, then XORed with the keystream. Output backpressure is handled by stalling the whole core. It sits between the storage-side stream interface and the core instance.

---
 rtl/aes_ctr_pkg.sv | 15 +
 rtl/aes_ctr_pt_fifo.sv | 72 +++++++
 rtl/aes_ctr_sched.sv | 158 +++++++++++++++
 tb/tb_aes_ctr_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctr_pkg.sv
// Shared types and constants for the AES-256 CTR-mode sequencer.
// Holds the FSM state enum, block/key widths and the default core latency.
package aes_ctr_pkg;

    localparam int AES_BLK_W       = 128;
    localparam int AES_KEY_W       = 256;
    localparam int AES_LATENCY_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctr_state_e;

endpackage

// File: rtl/aes_ctr_pt_fifo.sv
// Plaintext FIFO that holds accepted blocks until their keystream emerges.
// Ports: clk, rst_n (async, active-low), push/wdata, pop/rdata, empty, full.
module aes_ctr_pt_fifo
    import aes_ctr_pkg::*;
#(
    parameter int DEPTH = AES_LATENCY_DEF,
    parameter int W     = AES_BLK_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= nxt(wptr);
            end
            if (do_pop) begin
                rptr <= nxt(rptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

    underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty));

endmodule

// File: rtl/aes_ctr_sched.sv
// CTR-mode sequencer around a pipelined AES-256 core with a global stall.
// Ports: cfg_* control, busy/done/ctr_wrap status, in_* / out_* valid-ready
// streams, core_en/core_state/core_key/core_out to the core instance.
// Optional macro AES_CTR_STATS_EN adds stat_blocks_in and stat_stall_cycles.
module aes_ctr_sched
    import aes_ctr_pkg::*;
#(
    parameter int AES_LATENCY = AES_LATENCY_DEF,
    parameter int CTR_W       = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_start,
    input  logic                       cfg_stop,
    input  logic [AES_KEY_W-1:0]       cfg_key,
    input  logic [AES_BLK_W-CTR_W-1:0] cfg_nonce,
    input  logic [CTR_W-1:0]           cfg_ctr_init,
    output logic                       busy,
    output logic                       done,
    output logic                       ctr_wrap,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AES_BLK_W-1:0]       in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [AES_BLK_W-1:0]       out_data,
    output logic                       core_en,
    output logic [AES_BLK_W-1:0]       core_state,
    output logic [AES_KEY_W-1:0]       core_key,
    input  logic [AES_BLK_W-1:0]       core_out
`ifdef AES_CTR_STATS_EN
    ,
    output logic [31:0]                stat_blocks_in,
    output logic [31:0]                stat_stall_cycles
`endif
);

    localparam int NONCE_W = AES_BLK_W - CTR_W;

    ctr_state_e             state_q;
    ctr_state_e             state_d;
    logic [AES_KEY_W-1:0]   key_q;
    logic [NONCE_W-1:0]     nonce_q;
    logic [CTR_W-1:0]       ctr_q;
    logic [AES_LATENCY-1:0] vsr_q;
    logic                   wrap_q;
    logic                   accept;
    logic                   pop;
    logic                   start_go;
    logic                   drain_done;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [AES_BLK_W-1:0]   fifo_head;

    // A valid block at the core output with no taker freezes everything.
    assign core_en    = !(vsr_q[AES_LATENCY-1] && !out_ready);
    assign in_ready   = (state_q == RUN) && core_en;
    assign accept     = in_valid && in_ready;
    assign out_valid  = vsr_q[AES_LATENCY-1];
    assign pop        = out_valid && out_ready;
    assign out_data   = core_out ^ fifo_head;
    assign busy       = (state_q != IDLE);
    assign ctr_wrap   = wrap_q;
    assign core_state = {nonce_q, ctr_q};
    assign core_key   = key_q;
    assign drain_done = (vsr_q == '0) && fifo_empty;

    always_comb begin
        state_d  = state_q;
        done     = 1'b0;
        start_go = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d  = RUN;
                    start_go = 1'b1;
                end
            end
            RUN: begin
                if (cfg_stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            nonce_q <= '0;
            ctr_q   <= '0;
            wrap_q  <= 1'b0;
            vsr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_go) begin
                key_q   <= cfg_key;
                nonce_q <= cfg_nonce;
                ctr_q   <= cfg_ctr_init;
                wrap_q  <= 1'b0;
            end else if (accept) begin
                ctr_q <= ctr_q + CTR_W'(1);
                if (&ctr_q) begin
                    wrap_q <= 1'b1;
                end
            end
            if (core_en) begin
                vsr_q <= (vsr_q << 1) | AES_LATENCY'(accept);
            end
        end
    end

    aes_ctr_pt_fifo #(
        .DEPTH (AES_LATENCY),
        .W     (AES_BLK_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // In-flight blocks are bounded by the valid shift register length.
    no_ovf_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && fifo_full && !pop));

`ifdef AES_CTR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_blocks_in    <= '0;
            stat_stall_cycles <= '0;
        end else if (start_go) begin
            stat_blocks_in    <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (accept && !(&stat_blocks_in)) begin
                stat_blocks_in <= stat_blocks_in + 32'd1;
            end
            if (!core_en && !(&stat_stall_cycles)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_ctr_sched.sv
// Self-checking bench for aes_ctr_sched with a behavioural stall-aware core.
// Scoreboard queue of expected ciphertext, NIST CTR-AES256 table, corner runs.
module tb_aes_ctr_sched;

    localparam int L = 15;

    localparam logic [255:0] NKEY =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [95:0]  NNONCE = 96'hf0f1f2f3f4f5f6f7f8f9fafb;
    localparam logic [31:0]  NCTR   = 32'hfcfdfeff;
    localparam logic [127:0] NPT [4] = '{
        128'h6bc1bee22e409f96e93d7e117393172a,
        128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef,
        128'hf69f2445df4f9b17ad2b417be66c3710
    };
    localparam logic [127:0] NCT [4] = '{
        128'h601ec313775789a5b7a7f504bbf3d228,
        128'hf443e3ca4d62b59aca84e990cacaf5c5,
        128'h2b0930daa23de94ce87017ba2d84988d,
        128'hdfc9c58db67aada613c2dd08457941a6
    };
    localparam logic [31:0] WRAP_CTR [4] = '{
        32'hffff_fffe, 32'hffff_ffff, 32'h0000_0000, 32'h0000_0001
    };

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_start = 1'b0;
    logic         cfg_stop = 1'b0;
    logic [255:0] cfg_key = '0;
    logic [95:0]  cfg_nonce = '0;
    logic [31:0]  cfg_ctr_init = '0;
    logic         busy, done, ctr_wrap;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         core_en;
    logic [127:0] core_state;
    logic [255:0] core_key;
    logic [127:0] core_out;
`ifdef AES_CTR_STATS_EN
    logic [31:0]  stat_blocks_in, stat_stall_cycles;
`endif

    int           total = 0;
    int           bad = 0;
    int           done_cnt = 0;
    bit           rand_ready = 1'b0;
    longint       hs_t = -1;
    longint       ov_t = -1;
    logic [127:0] exp_q [$];
    logic [255:0] m_key;
    logic [95:0]  m_nonce;
    logic [31:0]  m_ctr;
    vec_t         tv [4];
    logic [127:0] cpipe [L];

    always #5 clk = ~clk;

    aes_ctr_sched #(.AES_LATENCY(L), .CTR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_key      (cfg_key),
        .cfg_nonce    (cfg_nonce),
        .cfg_ctr_init (cfg_ctr_init),
        .busy         (busy),
        .done         (done),
        .ctr_wrap     (ctr_wrap),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .core_en      (core_en),
        .core_state   (core_state),
        .core_key     (core_key),
        .core_out     (core_out)
`ifdef AES_CTR_STATS_EN
        ,
        .stat_blocks_in    (stat_blocks_in),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    // Stand-in for the AES core: NIST keystream for the NIST inputs,
    // a key-dependent mix otherwise.
    function automatic logic [127:0] core_f(input logic [127:0] s,
                                            input logic [255:0] k);
        logic [127:0] r;
        r = {s[95:0], s[127:96]} ^ k[255:128] ^ ~k[127:0]
            ^ 128'h9e3779b97f4a7c15f39cc0605cedc834;
        for (int i = 0; i < 4; i++) begin
            if (k == NKEY && s == {NNONCE, NCTR + 32'(i)}) begin
                r = NPT[i] ^ NCT[i];
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (core_en) begin
            cpipe[0] <= core_f(core_state, core_key);
            for (int i = 1; i < L; i++) begin
                cpipe[i] <= cpipe[i-1];
            end
        end
    end
    assign core_out = cpipe[L-1];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            if (out_valid) begin
                total++;
                bad++;
                $display("FAIL out_valid_in_reset: got 1 want 0");
            end
        end else begin
            if (done) done_cnt++;
            if (out_valid && ov_t < 0) ov_t = $time;
            chk("stall_rule", core_en, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_out: got %0h want none", out_data);
                end else begin
                    chk("ct", out_data, exp_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [255:0] k, input logic [95:0] n,
                         input logic [31:0] c);
        m_key = k;
        m_nonce = n;
        m_ctr = c;
        cfg_key = k;
        cfg_nonce = n;
        cfg_ctr_init = c;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        done_cnt = 0;
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] e,
                        input bit stop);
        int n = 0;
        in_valid = 1'b1;
        in_data = pt;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready 0 want 1");
        end else begin
            if (hs_t < 0) hs_t = $time;
            exp_q.push_back(e);
        end
        cfg_stop = stop;
        tick();
        in_valid = 1'b0;
        cfg_stop = 1'b0;
    endtask

    task automatic send_m(input logic [127:0] pt, input bit stop);
        logic [127:0] e;
        e = core_f({m_nonce, m_ctr}, m_key) ^ pt;
        m_ctr = m_ctr + 32'd1;
        send(pt, e, stop);
    endtask

    task automatic wait_out(input string nm);
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_outstanding"}, 256'(exp_q.size()), 0);
    endtask

    task automatic finish_run(input string nm);
        int n = 0;
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done_cnt"}, 256'(done_cnt), 1);
        chk({nm, "_drained"}, 256'(exp_q.size()), 0);
        tick();
    endtask

    task automatic run_nist(input string nm);
        start(NKEY, NNONCE, NCTR);
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_in_ready"}, in_ready, 1);
        hs_t = -1;
        ov_t = -1;
        for (int i = 0; i < 4; i++) begin
            send(tv[i].pt, tv[i].ct, 1'b0);
        end
        wait_out(nm);
        chk({nm, "_latency"}, 256'(ov_t - hs_t), 256'(L * 10));
        finish_run(nm);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tv[i].pt = NPT[i];
            tv[i].ct = NCT[i];
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", ctr_wrap, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_core_en", core_en, 1);
        chk("rst_core_key", core_key, 0);
        chk("rst_core_state", core_state, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 0);

        run_nist("nist");

        // A second start while running must not disturb key or counter.
        start(~NKEY, 96'h0102030405060708090a0b0c, 32'h10);
        send_m(128'h1111, 1'b0);
        send_m(128'h2222, 1'b0);
        cfg_key = NKEY;
        cfg_ctr_init = 32'h5555_0000;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("restart_busy", busy, 1);
        send_m(128'h3333, 1'b0);
        send_m(128'h4444, 1'b0);
        wait_out("restart");
        finish_run("restart");

        start(256'hfeed_0001, 96'hcafe, 32'h100);
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_m({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
        wait_out("burst");
        rand_ready = 1'b0;
        tick();
        tick();
        out_ready = 1'b1;
        finish_run("burst");

        start(256'hbeef_0002, 96'h77, 32'hffff_fffe);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_ctr", core_state, {96'h77, WRAP_CTR[i]});
            send_m(128'(i + 100), 1'b0);
            chk("wrap_flag", ctr_wrap, (i >= 1));
        end
        wait_out("wrap");
        finish_run("wrap");
        chk("wrap_sticky", ctr_wrap, 1);
        start(256'hbeef_0003, 96'h78, 32'h0);
        chk("wrap_clear", ctr_wrap, 0);
        finish_run("wrap2");

        start(256'habcd_0004, 96'h99, 32'h20);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_m(128'(i * 7 + 3), (i == 4));
        end
        @(negedge clk);
        chk("stop_in_ready", in_ready, 0);
        chk("stop_busy", busy, 1);
        repeat (20) @(negedge clk);
        chk("stop_held_valid", out_valid, 1);
        chk("stop_core_en", core_en, 0);
        tick();
        out_ready = 1'b1;
        wait_out("stop");
        finish_run("stop");

        start(NKEY, NNONCE, 32'h4000);
        for (int i = 0; i < 8; i++) begin
            send_m(128'(i + 1), 1'b0);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rstmid_out_valid", out_valid, 0);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstmid_busy", busy, 0);
        chk("rstmid_fifo_empty", dut.u_fifo.empty, 1);
        for (int i = 0; i < L + 3; i++) begin
            @(negedge clk);
            chk("rstmid_no_residue", out_valid, 0);
        end
        tick();
        run_nist("nist_again");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
